frame_bank_scheduler: RTL and testbench
=======================================

Name: frame_bank_scheduler

Overview:
- Ping-pong controller for the two 8-bit edge-map BRAM banks between the hysteresis stage (producer) and the Hough stage (consumer).
- Steers producer writes into a free bank while the consumer drains the other bank.
- Issues a consumer start pulse when a frame is ready, and recycles banks on completion.
- Producer stalls when no bank is free.

Parameters:
- WIDTH, 640, image width in pixels.
- HEIGHT, 480, image height in pixels.
- ADDR_W, $clog2(WIDTH*HEIGHT), pixel address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  producer pixel write strobe
- wr_addr  in  ADDR_W  producer pixel address
- wr_data  in  8  producer pixel value
- wr_frame_done  in  1  one-cycle pulse; producer finished the frame
- wr_stall  out  1  producer must hold off; no bank is accepting writes
- rd_start  out  1  one-cycle pulse; a frame is available to the consumer
- rd_en  in  1  consumer read strobe
- rd_addr  in  ADDR_W  consumer read address
- rd_data  out  8  read data from the draining bank
- rd_valid  out  1  rd_data valid, 1 cycle after an accepted rd_en
- rd_frame_done  in  1  one-cycle pulse; consumer finished the frame
- b0_wr_en, b1_wr_en  out  1  bank write enables
- b0_addr, b1_addr  out  ADDR_W  bank addresses
- b0_wr_data, b1_wr_data  out  8  bank write data
- b0_rd_data, b1_rd_data  in  8  bank read data (synchronous BRAM, 1-cycle latency)
- frames_done  out  16  count of consumer-completed frames, wraps at 2^16
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`; the reset condition is sampled only at the rising edge of `clock`.
- Bank state: each bank holds one of FREE, FILLING, READY, DRAINING. All state is registered.
- wbank / rbank pointers: wbank names the FILLING bank. rbank names the next bank to read; frames alternate banks, so rbank toggles on each rd_start.
- Reset values:
  - bank0 = FILLING, bank1 = FREE, wbank = 0, rbank = 0.
  - wr_stall = 0, rd_start = 0, rd_valid = 0, rd_data = 0.
  - frames_done = 0, proto_err = 0.
  - All bank strobes = 0.
  - Reset mid-frame discards both banks' contents logically.
- Write path (combinational):
  - While a bank is FILLING and wr_stall = 0, wr_en/wr_addr/wr_data route to bank[wbank].
  - The other bank's wr_en = 0.
- wr_frame_done:
  - bank[wbank] becomes READY. A write in the same cycle is still committed to that bank.
  - If the other bank is FREE, it becomes FILLING and wbank toggles, all in the same clock edge; wr_stall stays 0.
  - Otherwise there is no FILLING bank and wr_stall = 1 from the next cycle.
- Stall release:
  - A bank reaching FREE while no bank is FILLING becomes FILLING at the same edge, and wbank points to it.
  - wr_stall deasserts the cycle after the FREE transition.
  - wr_en during stall is dropped, and proto_err is set.
- Read scheduling:
  - When no bank is DRAINING and bank[rbank] is READY, pulse rd_start for 1 cycle.
  - At that edge, bank[rbank] becomes DRAINING and rbank toggles.
  - Minimum latency from wr_frame_done to rd_start is 1 cycle.
- Read path:
  - While a bank is DRAINING, rd_addr drives that bank's address.
  - The bank mux select is registered together with rd_en. rd_data is the selected bN_rd_data, and rd_valid = 1 exactly 1 cycle after rd_en.
  - rd_en with no DRAINING bank: rd_valid stays 0 and proto_err is set.
- Bank address mux: bN_addr = wr_addr when bank N is FILLING, rd_addr when DRAINING, 0 otherwise.
- rd_frame_done:
  - The DRAINING bank becomes FREE and frames_done increments.
  - If no bank is DRAINING, the pulse is ignored and proto_err is set.
- Simultaneous wr_frame_done and rd_frame_done:
  - Both are processed at one edge.
  - With bank A FILLING and bank B DRAINING: A becomes READY, B becomes FREE and then FILLING (wbank = B), no stall.
  - rd_start for A fires on the following cycle.
- Invariant: at most one bank is DRAINING and at most one is FILLING at any time.

Optional Feature:
- Macro: FRAME_DROP_EN.
- Defined: a wr_frame_done with no FREE other bank does not stall.
  - bank[wbank] stays FILLING and its frame is discarded; the next frame overwrites it.
  - The dropped frame never reaches the consumer.
  - Adds output frames_dropped [15:0], which resets to 0 and increments per discard.
  - wr_stall is tied to 0.
- Undefined: stall behaviour as above, and there is no frames_dropped port.

Test Plan:
- Reset, write 4 pixels to bank0 (addr 0..3, data 0x10..0x13), pulse wr_frame_done -> rd_start high the next cycle, bank1 FILLING, wr_stall = 0. Reads of addr 0..3 return 0x10..0x13 with rd_valid 1 cycle after each rd_en.
- While bank0 is DRAINING, fill bank1 and pulse wr_frame_done -> wr_stall = 1 the next cycle. Then pulse rd_frame_done -> wr_stall = 0 one cycle later, rd_start fires for bank1, frames_done = 1.
- Pulse wr_frame_done and rd_frame_done in the same cycle (bank0 FILLING, bank1 DRAINING) -> no stall, bank1 FILLING, rd_start for bank0 the next cycle.
- Pulse rd_frame_done with no DRAINING bank, and assert wr_en during stall -> proto_err = 1 and sticky until reset; bank contents are unchanged.
- Assert reset mid-drain -> all outputs return to reset values the next cycle, bank0 FILLING, and no rd_start until a new wr_frame_done.
- With FRAME_DROP_EN, complete 3 frames while the consumer holds bank0 -> wr_stall stays 0, frames_dropped = 1, and the consumer receives only frames 1 and 3.

Source files
------------

// File: rtl/frame_bank_scheduler.sv
// Ping-pong scheduler for the two edge-map banks between hysteresis (writer) and Hough (reader).
// Optional FRAME_DROP_EN: the writer never stalls; a frame with no free bank to move on to is discarded.
module frame_bank_scheduler #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = $clog2(WIDTH*HEIGHT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              wr_frame_done,
  output logic              wr_stall,
  output logic              rd_start,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              rd_frame_done,
  output logic              b0_wr_en,
  output logic              b1_wr_en,
  output logic [ADDR_W-1:0] b0_addr,
  output logic [ADDR_W-1:0] b1_addr,
  output logic [7:0]        b0_wr_data,
  output logic [7:0]        b1_wr_data,
  input  logic [7:0]        b0_rd_data,
  input  logic [7:0]        b1_rd_data,
  output logic [15:0]       frames_done,
`ifdef FRAME_DROP_EN
  output logic [15:0]       frames_dropped,
`endif
  output logic              proto_err
);

  typedef enum logic [1:0] {FREE, FILLING, READY, DRAINING} bank_st_t;

  bank_st_t [1:0] bst, bst_n;
  logic           wbank, wbank_n, rbank, rbank_n;
  logic           rd_sel;
  logic           drain_any, drain_idx, fill_any;
  logic           fd_inc, rd_err, drop;

  logic [1:0]             bk_wr_en;
  logic [1:0][ADDR_W-1:0] bk_addr;
  logic [1:0][7:0]        bk_wr_data;
  logic [1:0][7:0]        bk_rd_data;

  assign drain_any = (bst[0] == DRAINING) || (bst[1] == DRAINING);
  assign drain_idx = (bst[1] == DRAINING);
  assign fill_any  = (bst[0] == FILLING) || (bst[1] == FILLING);
  assign rd_start  = !drain_any && (bst[rbank] == READY);

`ifdef FRAME_DROP_EN
  assign wr_stall = 1'b0;
`else
  assign wr_stall = !fill_any;
`endif

  always_comb begin
    bst_n   = bst;
    wbank_n = wbank;
    rbank_n = rbank;
    fd_inc  = 1'b0;
    rd_err  = 1'b0;
    drop    = 1'b0;
    if (rd_frame_done) begin
      if (drain_any) begin
        bst_n[drain_idx] = FREE;
        fd_inc = 1'b1;
      end else begin
        rd_err = 1'b1;
      end
    end
    // Release is applied first so a simultaneous drain-done counts as a free bank.
    if (wr_frame_done && bst[wbank] == FILLING) begin
`ifdef FRAME_DROP_EN
      if (bst_n[~wbank] == FREE) bst_n[wbank] = READY;
      else                       drop = 1'b1;
`else
      bst_n[wbank] = READY;
`endif
    end
    if (rd_start) begin
      bst_n[rbank] = DRAINING;
      rbank_n = ~rbank;
    end
    if (bst_n[0] != FILLING && bst_n[1] != FILLING) begin
      if (bst_n[0] == FREE) begin
        bst_n[0] = FILLING;
        wbank_n  = 1'b0;
      end else if (bst_n[1] == FREE) begin
        bst_n[1] = FILLING;
        wbank_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bst[0]      <= FILLING;
      bst[1]      <= FREE;
      wbank       <= 1'b0;
      rbank       <= 1'b0;
      rd_valid    <= 1'b0;
      rd_sel      <= 1'b0;
      frames_done <= 16'd0;
      proto_err   <= 1'b0;
    end else begin
      bst      <= bst_n;
      wbank    <= wbank_n;
      rbank    <= rbank_n;
      rd_valid <= rd_en && drain_any;
      rd_sel   <= drain_idx;
      if (fd_inc) frames_done <= frames_done + 16'd1;
      if ((wr_en && wr_stall) || (rd_en && !drain_any) || rd_err) proto_err <= 1'b1;
    end
  end

`ifdef FRAME_DROP_EN
  always_ff @(posedge clock) begin
    if (reset)     frames_dropped <= 16'd0;
    else if (drop) frames_dropped <= frames_dropped + 16'd1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_bank
    assign bk_wr_en[g]   = wr_en && !wr_stall && bst[g] == FILLING && wbank == 1'(g);
    assign bk_wr_data[g] = (bst[g] == FILLING) ? wr_data : 8'h00;
    assign bk_addr[g]    = (bst[g] == FILLING)  ? wr_addr :
                           (bst[g] == DRAINING) ? rd_addr : '0;
  end

  assign bk_rd_data = {b1_rd_data, b0_rd_data};
  assign rd_data    = rd_valid ? bk_rd_data[rd_sel] : 8'h00;

  assign b0_wr_en   = bk_wr_en[0];
  assign b1_wr_en   = bk_wr_en[1];
  assign b0_addr    = bk_addr[0];
  assign b1_addr    = bk_addr[1];
  assign b0_wr_data = bk_wr_data[0];
  assign b1_wr_data = bk_wr_data[1];

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed bench for frame_bank_scheduler with two behavioural 1-cycle-latency BRAM banks.
module tb_frame_bank_scheduler;
  localparam int WIDTH  = 8;
  localparam int HEIGHT = 4;
  localparam int ADDR_W = $clog2(WIDTH*HEIGHT);

  logic              clock = 1'b0;
  logic              reset;
  logic              wr_en, wr_frame_done, rd_en, rd_frame_done;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [7:0]        wr_data;
  logic              wr_stall, rd_start, rd_valid, proto_err;
  logic [7:0]        rd_data;
  logic              b0_wr_en, b1_wr_en;
  logic [ADDR_W-1:0] b0_addr, b1_addr;
  logic [7:0]        b0_wr_data, b1_wr_data;
  logic [7:0]        b0_rd_data, b1_rd_data;
  logic [15:0]       frames_done;
`ifdef FRAME_DROP_EN
  logic [15:0]       frames_dropped;
`endif

  int nchk = 0;
  int nerr = 0;

  frame_bank_scheduler #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_frame_done(wr_frame_done), .wr_stall(wr_stall),
    .rd_start(rd_start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_frame_done(rd_frame_done),
    .b0_wr_en(b0_wr_en), .b1_wr_en(b1_wr_en),
    .b0_addr(b0_addr), .b1_addr(b1_addr),
    .b0_wr_data(b0_wr_data), .b1_wr_data(b1_wr_data),
    .b0_rd_data(b0_rd_data), .b1_rd_data(b1_rd_data),
    .frames_done(frames_done),
`ifdef FRAME_DROP_EN
    .frames_dropped(frames_dropped),
`endif
    .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  logic [7:0] mem0 [2**ADDR_W];
  logic [7:0] mem1 [2**ADDR_W];
  always @(posedge clock) begin
    if (b0_wr_en) mem0[b0_addr] <= b0_wr_data;
    if (b1_wr_en) mem1[b1_addr] <= b1_wr_data;
    b0_rd_data <= mem0[b0_addr];
    b1_rd_data <= mem1[b1_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wr_px(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = 8'(d);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic rd_px(input string tag, input int a, input int d);
    rd_en   = 1'b1;
    rd_addr = ADDR_W'(a);
    tick();
    rd_en   = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"},  32'(rd_data),  32'(d));
  endtask

  task automatic pulse(input logic wfd, input logic rfd);
    wr_frame_done = wfd;
    rd_frame_done = rfd;
    tick();
    wr_frame_done = 1'b0;
    rd_frame_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_frame_done = 1'b0; rd_en = 1'b0; rd_frame_done = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = 8'h00;
    tick(); tick();
    chk("rst_stall",  32'(wr_stall),    32'd0);
    chk("rst_start",  32'(rd_start),    32'd0);
    chk("rst_valid",  32'(rd_valid),    32'd0);
    chk("rst_data",   32'(rd_data),     32'd0);
    chk("rst_frames", 32'(frames_done), 32'd0);
    chk("rst_perr",   32'(proto_err),   32'd0);
    chk("rst_b0we",   32'(b0_wr_en),    32'd0);
    chk("rst_b1we",   32'(b1_wr_en),    32'd0);
    reset = 1'b0;
    tick();

    // Frame A into bank0, consumer drains it
    for (int i = 0; i < 4; i++) wr_px(i, 8'h10 + i);
    pulse(1'b1, 1'b0);
    chk("a_start", 32'(rd_start), 32'd1);
    chk("a_stall", 32'(wr_stall), 32'd0);
    tick();
    chk("a_start_pulse", 32'(rd_start), 32'd0);
    for (int i = 0; i < 4; i++) rd_px("a_rd", i, 8'h10 + i);
    tick();
    chk("a_valid_drop", 32'(rd_valid), 32'd0);

    // Frame B into bank1 while bank0 drains
    wr_en = 1'b1; wr_addr = ADDR_W'(1); wr_data = 8'h21;
    #1;
    chk("b_b1we",   32'(b1_wr_en), 32'd1);
    chk("b_b0we",   32'(b0_wr_en), 32'd0);
    chk("b_b1addr", 32'(b1_addr),  32'd1);
    chk("b_b0addr", 32'(b0_addr),  32'd3);
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) wr_px(i, 8'h20 + i);
    pulse(1'b1, 1'b0);
    chk("b_stall", 32'(wr_stall), 32'd1);
    chk("b_nostart", 32'(rd_start), 32'd0);
    wr_en = 1'b1; wr_addr = '0; wr_data = 8'hEE;
    #1;
    chk("b_stall_we", 32'({b1_wr_en, b0_wr_en}), 32'd0);
    tick();
    wr_en = 1'b0;
    chk("b_perr", 32'(proto_err), 32'd1);
    pulse(1'b0, 1'b1);
    chk("b_unstall", 32'(wr_stall),    32'd0);
    chk("b_frames",  32'(frames_done), 32'd1);
    chk("b_start",   32'(rd_start),    32'd1);
    tick();
    for (int i = 0; i < 4; i++) rd_px("b_rd", i, 8'h20 + i);

    // Frame C into bank0 with simultaneous done on both sides
    wr_px(0, 8'h30);
    wr_px(1, 8'h31);
    pulse(1'b1, 1'b1);
    chk("c_stall",  32'(wr_stall),    32'd0);
    chk("c_frames", 32'(frames_done), 32'd2);
    chk("c_start",  32'(rd_start),    32'd1);
    chk("c_perr_sticky", 32'(proto_err), 32'd1);
    wr_en = 1'b1; wr_addr = ADDR_W'(5); wr_data = 8'h55;
    #1;
    chk("c_b1we", 32'(b1_wr_en), 32'd1);
    wr_en = 1'b0;
    tick();
    rd_px("c_rd0", 0, 8'h30);
    rd_px("c_rd1", 1, 8'h31);

    // Reset while bank0 drains
    rd_en = 1'b1; rd_addr = ADDR_W'(2);
    reset = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("r_valid",  32'(rd_valid),    32'd0);
    chk("r_frames", 32'(frames_done), 32'd0);
    chk("r_perr",   32'(proto_err),   32'd0);
    chk("r_stall",  32'(wr_stall),    32'd0);
    chk("r_start",  32'(rd_start),    32'd0);
    reset = 1'b0;
    tick(); tick();
    chk("r_nostart", 32'(rd_start), 32'd0);
    rd_addr = ADDR_W'(7);
    wr_en = 1'b1; wr_addr = ADDR_W'(2); wr_data = 8'h77;
    #1;
    chk("r_b0we",   32'(b0_wr_en), 32'd1);
    chk("r_b0addr", 32'(b0_addr),  32'd2);
    chk("r_b1addr", 32'(b1_addr),  32'd0);
    wr_en = 1'b0;

    // Protocol errors with nothing draining
    pulse(1'b0, 1'b1);
    chk("p_perr",   32'(proto_err),   32'd1);
    chk("p_frames", 32'(frames_done), 32'd0);
    rd_px_none: begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("p_rd_valid", 32'(rd_valid), 32'd0);
    end

`ifdef FRAME_DROP_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    wr_px(0, 8'h41);
    pulse(1'b1, 1'b0);
    chk("d_start1", 32'(rd_start), 32'd1);
    tick();
    wr_px(0, 8'h42);
    pulse(1'b1, 1'b0);
    chk("d_stall",   32'(wr_stall),       32'd0);
    chk("d_dropped", 32'(frames_dropped), 32'd1);
    chk("d_nostart", 32'(rd_start),       32'd0);
    rd_px("d_rd1", 0, 8'h41);
    pulse(1'b0, 1'b1);
    chk("d_nostart2", 32'(rd_start), 32'd0);
    wr_px(0, 8'h43);
    pulse(1'b1, 1'b0);
    chk("d_start3",   32'(rd_start),       32'd1);
    chk("d_dropped2", 32'(frames_dropped), 32'd1);
    tick();
    rd_px("d_rd3", 0, 8'h43);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
